// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_REQUEST = 2'd0,
    FETCH_WAIT    = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_t;

  localparam int INSTRUCTION_BYTES = 4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one memory request in flight and
// holds each returned word in a single-entry register toward decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0]     imem_req_addr,
  input  logic                         imem_resp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_resp_data,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_data,
  output logic [ADDRESS_WIDTH-1:0]     instruction_pc,
  output logic                         instruction_valid,
  input  logic                         instruction_ready,
  input  logic                         redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]     redirect_pc,
  output logic                         fetch_misaligned
);

  fetch_state_t             state;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] inflight_pc;
  logic                     req_fire;

  function automatic logic [ADDRESS_WIDTH-1:0] word_align(input logic [ADDRESS_WIDTH-1:0] a);
    return {a[ADDRESS_WIDTH-1:2], 2'b00};
  endfunction

  // Only issue when the output register is guaranteed free by the time the word lands.
  assign imem_req_valid = rst && (state == FETCH_REQUEST) &&
                          (!instruction_valid || instruction_ready);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= FETCH_REQUEST;
      pc                <= RESET_PC;
      inflight_pc       <= RESET_PC;
      instruction_valid <= 1'b0;
      instruction_data  <= '0;
      instruction_pc    <= '0;
      fetch_misaligned  <= 1'b0;
    end else begin
      fetch_misaligned <= 1'b0;
      if (instruction_valid && instruction_ready)
        instruction_valid <= 1'b0;

      unique case (state)
        FETCH_REQUEST: begin
          if (req_fire) begin
            inflight_pc <= pc;
            state       <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (imem_resp_valid) begin
            instruction_data  <= imem_resp_data;
            instruction_pc    <= inflight_pc;
            instruction_valid <= 1'b1;
            pc                <= inflight_pc + ADDRESS_WIDTH'(INSTRUCTION_BYTES);
            state             <= FETCH_REQUEST;
          end
        end
        FETCH_DISCARD: begin
          if (imem_resp_valid)
            state <= FETCH_REQUEST;
        end
        default: state <= FETCH_REQUEST;
      endcase

      // Redirect overrides everything above: flush the output and retarget the PC.
      if (redirect_valid) begin
        pc                <= word_align(redirect_pc);
        instruction_valid <= 1'b0;
        fetch_misaligned  <= |redirect_pc[1:0];
        unique case (state)
          FETCH_REQUEST: state <= req_fire ? FETCH_DISCARD : FETCH_REQUEST;
          FETCH_WAIT:    state <= imem_resp_valid ? FETCH_REQUEST : FETCH_DISCARD;
          FETCH_DISCARD: state <= imem_resp_valid ? FETCH_REQUEST : FETCH_DISCARD;
          default:       state <= FETCH_REQUEST;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a transaction-level memory and PC model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic [31:0] instruction_data;
  logic [31:0] instruction_pc;
  logic        instruction_valid;
  logic        instruction_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_misaligned;

  fetch_unit #(.ADDRESS_WIDTH(32), .INSTRUCTION_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instruction_data(instruction_data), .instruction_pc(instruction_pc),
    .instruction_valid(instruction_valid), .instruction_ready(instruction_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } item_t;

  item_t       exp_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          consumed = 0;

  // Reference state: next PC the fetcher must request, and the memory's one pending access.
  logic [31:0] exp_next_pc = RESET_PC;
  logic        exp_mis = 1'b0;
  logic        seen_reset = 1'b0;
  logic        after_reset = 1'b0;
  logic        mem_pending = 1'b0;
  logic        mem_live = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic rv,
                      input logic [31:0] rpc, input logic rqr);
    @(negedge clk);
    rst = r; instruction_ready = rdy; redirect_valid = rv; redirect_pc = rpc; imem_req_ready = rqr;
    if (r && mem_pending && mem_cnt == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (mem_pending && mem_cnt > 0) mem_cnt--;
    end
    #1;
    if (seen_reset) check("misaligned", 64'(fetch_misaligned), 64'(exp_mis));
    if (after_reset && r) begin
      check("reset_valid", 64'(instruction_valid), 64'd0);
      check("reset_data", 64'(instruction_data), 64'd0);
      check("reset_pc", 64'(instruction_pc), 64'd0);
    end
    if (!r) begin
      check("req_in_reset", 64'(imem_req_valid), 64'd0);
      mem_pending = 1'b0; mem_live = 1'b0;
      exp_q.delete();
      exp_next_pc = RESET_PC;
      exp_mis = 1'b0;
      seen_reset = 1'b1; after_reset = 1'b1;
    end else begin
      after_reset = 1'b0;
      if (instruction_valid && !rdy) check("req_gate", 64'(imem_req_valid), 64'd0);
      if (imem_resp_valid) begin
        mem_pending = 1'b0;
        if (mem_live && !rv) begin
          exp_q.push_back('{mem_addr, mem_word(mem_addr)});
          exp_next_pc = mem_addr + 32'd4;
        end
      end
      if (imem_req_valid && rqr) begin
        check("req_addr", 64'(imem_req_addr), 64'(exp_next_pc));
        check("one_outstanding", 64'(mem_pending), 64'd0);
        mem_pending = 1'b1; mem_live = 1'b1; mem_addr = imem_req_addr;
        mem_cnt = $urandom_range(0, 2);
      end
      if (rv) begin
        mem_live = 1'b0;
        exp_q.delete();
        exp_next_pc = {rpc[31:2], 2'b00};
      end
      exp_mis = rv && (rpc[1:0] != 2'b00);
    end
  endtask

  // Monitor: pops the scoreboard on every decode handshake, checks hold and flush.
  initial begin : monitor
    logic        have_prev;
    logic        prev_hold;
    logic        prev_flush;
    logic [31:0] prev_data;
    logic [31:0] prev_pc;
    item_t       it;
    have_prev = 1'b0; prev_hold = 1'b0; prev_flush = 1'b0; prev_data = '0; prev_pc = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev && prev_hold) begin
          check("hold_valid", 64'(instruction_valid), 64'd1);
          check("hold_data", 64'(instruction_data), 64'(prev_data));
          check("hold_pc", 64'(instruction_pc), 64'(prev_pc));
        end
        if (have_prev && prev_flush) check("flush_valid", 64'(instruction_valid), 64'd0);
        if (instruction_valid && instruction_ready && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_instr: got pc %0h data %0h, expected none", instruction_pc, instruction_data);
          end else begin
            it = exp_q.pop_front();
            check("instr_pc", 64'(instruction_pc), 64'(it.pc));
            check("instr_data", 64'(instruction_data), 64'(it.data));
          end
          consumed++;
        end
        prev_hold  = instruction_valid && !instruction_ready && !redirect_valid;
        prev_flush = redirect_valid;
        prev_data  = instruction_data;
        prev_pc    = instruction_pc;
        have_prev  = 1'b1;
      end
    end
  end

  initial begin : stimulus
    logic [31:0] targets [4];
    logic [31:0] t;
    targets[0] = 32'h0000_0100; targets[1] = 32'h0000_0200;
    targets[2] = 32'h0000_0102; targets[3] = 32'hFFFF_FFFC;

    repeat (3) step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    repeat (10) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    repeat (6) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b0, '0, 1'b1);

    // Directed redirects to aligned, misaligned and wrap targets.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, targets[i], 1'b1);
      repeat (8) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    end

    for (int i = 0; i < 600; i++) begin
      t = ($urandom_range(0, 3) == 0) ? $urandom : targets[$urandom_range(0, 3)];
      step(1'b1, ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 8), t,
           ($urandom_range(0, 99) < 70));
    end

    // Wrap past the top of the address space, then reset in the middle of a fetch.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    repeat (10) step(1'b1, 1'b1, 1'b0, '0, 1'b1);

    // Drain: stop issuing so the last word is delivered and consumed.
    repeat (8) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    #3;
    check("drain_queue", 64'(exp_q.size()), 64'd0);
    check("drain_valid", 64'(instruction_valid), 64'd0);
    check("progress", 64'(consumed > 100), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
